core_wb_arbiter: RTL and testbench

//  N-master to 1-slave arbiter for the pipelined Wishbone bus used by core_if/core_mau.

---
 rtl/core_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_core_wb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/core_wb_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter. The grant is held for a whole cyc.
// The arbiter counts outstanding strobes and returns ack/err only to the current owner.

module core_wb_arbiter_port (
  input  logic owned,
  input  logic has_out,
  input  logic full,
  input  logic s_ack,
  input  logic s_err,
  input  logic s_stall,
  output logic m_ack,
  output logic m_err,
  output logic m_stall
);
  assign m_stall = owned ? (s_stall | full) : 1'b1;
  assign m_ack   = owned & has_out & s_ack;
  assign m_err   = owned & has_out & s_err;
endmodule

module core_wb_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PRIO_MODE       = 0,
  localparam int SEL_W = DATA_W / 8,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w,
  output logic [DATA_W-1:0]             m_dat_r,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [NUM_MASTERS-1:0]        m_stall,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [SEL_W-1:0]              s_sel,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_w,
  input  logic [DATA_W-1:0]             s_dat_r,
  input  logic                          s_ack,
  input  logic                          s_err,
  input  logic                          s_stall,
  output logic [IDX_W-1:0]              gnt_idx
);
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] gnt_nx, rr_last, rr_nx, win;
  logic [CNT_W-1:0] outstanding, out_nx;
  logic             grant, own_cyc, full, has_out, accept, retire;
  int unsigned      scan_idx;

  assign grant   = (state == GRANT);
  assign own_cyc = m_cyc[gnt_idx];
  assign full    = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign has_out = (outstanding != '0);

  assign s_cyc   = grant & own_cyc;
  assign s_stb   = s_cyc & m_stb[gnt_idx] & ~full;
  assign s_we    = m_we[gnt_idx];
  assign s_sel   = m_sel[int'(gnt_idx)*SEL_W +: SEL_W];
  assign s_adr   = m_adr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign s_dat_w = m_dat_w[int'(gnt_idx)*DATA_W +: DATA_W];
  assign m_dat_r = s_dat_r;

  assign accept  = s_stb & ~s_stall;
  // Responses arriving with nothing outstanding (e.g. after an abort) are dropped.
  assign retire  = grant & has_out & (s_ack | s_err);

  always_comb begin
    win      = '0;
    scan_idx = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (PRIO_MODE == 1) scan_idx = k;
      else scan_idx = (int'(rr_last) + 1 + k) % NUM_MASTERS;
      // Scanning backwards lets the highest-priority requester overwrite last.
      if (m_cyc[scan_idx]) win = IDX_W'(scan_idx);
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_idx;
    rr_nx    = rr_last;
    out_nx   = outstanding;
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_nx = GRANT;
          gnt_nx   = win;
          if (PRIO_MODE == 0) rr_nx = win;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_nx = IDLE;
          out_nx   = '0;
        end else if (accept && !retire) begin
          out_nx = outstanding + 1'b1;
        end else if (retire && !accept) begin
          out_nx = outstanding - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gnt_idx     <= '0;
      rr_last     <= IDX_W'(NUM_MASTERS - 1);
      outstanding <= '0;
    end else begin
      state       <= state_nx;
      gnt_idx     <= gnt_nx;
      rr_last     <= rr_nx;
      outstanding <= out_nx;
    end
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
    core_wb_arbiter_port u_port (
      .owned   (grant && (gnt_idx == IDX_W'(i))),
      .has_out (has_out),
      .full    (full),
      .s_ack   (s_ack),
      .s_err   (s_err),
      .s_stall (s_stall),
      .m_ack   (m_ack[i]),
      .m_err   (m_err[i]),
      .m_stall (m_stall[i])
    );
  end
endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: a round-robin instance and a fixed-priority instance.
module tb_core_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [7:0]  m_sel;
  logic [63:0] m_adr, m_dat_w;
  logic [31:0] m_dat_r, s_dat_r;
  logic [1:0]  m_ack, m_err, m_stall;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_w;
  logic        gnt_idx;

  logic [1:0]  f_cyc;
  logic [1:0]  f_ack, f_err, f_stall;
  logic [31:0] f_dat_r, f_adr, f_dat_w;
  logic        f_s_cyc, f_s_stb, f_s_we, f_gnt;
  logic [3:0]  f_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_wb_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr),
    .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
    .gnt_idx(gnt_idx)
  );

  core_wb_arbiter #(.PRIO_MODE(1)) u_fix (
    .clk(clk), .rst(rst),
    .m_cyc(f_cyc), .m_stb(2'b00), .m_we(2'b00), .m_sel(8'h00), .m_adr(64'h0),
    .m_dat_w(64'h0), .m_dat_r(f_dat_r), .m_ack(f_ack), .m_err(f_err), .m_stall(f_stall),
    .s_cyc(f_s_cyc), .s_stb(f_s_stb), .s_we(f_s_we), .s_sel(f_sel), .s_adr(f_adr),
    .s_dat_w(f_dat_w), .s_dat_r(32'h0), .s_ack(1'b0), .s_err(1'b0), .s_stall(1'b0),
    .gnt_idx(f_gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = 8'hFF;
    m_adr = '0; m_dat_w = '0; s_dat_r = '0; s_ack = 0; s_err = 0; s_stall = 0;
    f_cyc = '0;
    #3;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m_stall", m_stall, 2'b11);
    chk("rst_gnt", gnt_idx, 0);
    chk("rst_m_ack", m_ack, 2'b00);
    @(negedge clk); rst = 1'b1;
    tick();

    // T1: single read from m0
    m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h100; #1;
    chk("t1_idle_s_cyc", s_cyc, 0);
    chk("t1_idle_stall", m_stall, 2'b11);
    tick();
    chk("t1_s_cyc", s_cyc, 1);
    chk("t1_s_stb", s_stb, 1);
    chk("t1_s_adr", s_adr, 32'h100);
    chk("t1_stall", m_stall, 2'b10);
    tick();
    m_stb = 2'b00; s_ack = 1; s_dat_r = 32'hDEAD_BEEF; #1;
    chk("t1_m_ack", m_ack, 2'b01);
    chk("t1_dat_r", m_dat_r, 32'hDEAD_BEEF);
    tick();
    s_ack = 0; m_cyc = 2'b00; #1;
    chk("t1_ack_pulse", m_ack, 2'b00);
    tick();
    chk("t1_release", s_cyc, 0);

    // T2: round-robin contention right after reset
    rst = 1'b0; #1; rst = 1'b1;
    m_cyc = 2'b11; tick();
    chk("t2_first_m0", gnt_idx, 0);
    chk("t2_stall", m_stall, 2'b10);
    m_cyc = 2'b10; tick();
    chk("t2_idle_gap", s_cyc, 0);
    chk("t2_idle_stall", m_stall, 2'b11);
    tick();
    chk("t2_then_m1", gnt_idx, 1);
    chk("t2_m1_cyc", s_cyc, 1);
    m_cyc = 2'b01; tick();
    m_cyc = 2'b11; tick();
    chk("t2_back_m0", gnt_idx, 0);

    // T4: outstanding limit, m0 streams while the slave withholds ack
    m_stb = 2'b01; #1;
    chk("t4_stb0", s_stb, 1);
    tick(); tick(); tick(); tick();
    chk("t4_full_stb", s_stb, 0);
    chk("t4_full_stall", m_stall, 2'b11);
    s_ack = 1; #1;
    chk("t4_ack", m_ack, 2'b01);
    chk("t4_full_still", s_stb, 0);
    tick();
    s_ack = 0; #1;
    chk("t4_fifth_stb", s_stb, 1);
    chk("t4_fifth_stall", m_stall, 2'b10);
    tick();
    chk("t4_full_again", s_stb, 0);
    m_stb = 2'b00; s_ack = 1; tick(); tick();
    s_ack = 0; #1;
    chk("t4_no_ack", m_ack, 2'b00);

    // T5: m0 aborts with 2 outstanding, m1 waiting
    m_cyc = 2'b10; tick();
    s_ack = 1; #1;
    chk("t5_late_ack_idle", m_ack, 2'b00);
    chk("t5_idle", s_cyc, 0);
    tick();
    chk("t5_m1_gnt", gnt_idx, 1);
    chk("t5_late_ack_gnt", m_ack, 2'b00);
    s_ack = 0;

    // T6: reset mid-burst with 3 outstanding
    m_stb = 2'b10; m_dat_w[63:32] = 32'hCAFE_0001; #1;
    chk("t6_dat_w", s_dat_w, 32'hCAFE_0001);
    tick(); tick(); tick();
    chk("t6_not_full", s_stb, 1);
    #2; rst = 1'b0; #1;
    chk("t6_rst_s_cyc", s_cyc, 0);
    chk("t6_rst_stall", m_stall, 2'b11);
    chk("t6_rst_gnt", gnt_idx, 0);
    m_cyc = 2'b11; m_stb = 2'b00;
    @(posedge clk); #1; rst = 1'b1;
    tick();
    chk("t6_m0_first", gnt_idx, 0);
    s_ack = 1; #1;
    chk("t6_cnt_cleared", m_ack, 2'b00);
    s_ack = 0; m_cyc = 2'b00; tick();

    // T3: fixed priority instance
    f_cyc = 2'b11; tick();
    chk("t3_m0_first", f_gnt, 0);
    f_cyc = 2'b10; tick();
    chk("t3_idle", f_s_cyc, 0);
    f_cyc = 2'b11; tick();
    chk("t3_m0_again", f_gnt, 0);
    f_cyc = 2'b10; tick(); tick();
    chk("t3_m1_when_free", f_gnt, 1);
    chk("t3_m1_cyc", f_s_cyc, 1);
    f_cyc = 2'b00; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end
endmodule
